// File: rtl/queue_calc_pkg.sv
// Shared encodings for the queue calculator: queue commands, operator codes,
// error codes and the sequencer state type.
package queue_calc_pkg;

    localparam logic [1:0] Q_PUSH    = 2'b00;
    localparam logic [1:0] Q_NOP     = 2'b01;
    localparam logic [1:0] Q_REPLACE = 2'b10;
    localparam logic [1:0] Q_POP     = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_POP = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_OUT   = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/queue_calc_alu.sv
// Combinational ALU on the queue's front pair; results truncate to W bits.
module queue_calc_alu
    import queue_calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/queue_calc_sequencer.sv
// Token sequencer in front of the operand queue: issues push/replace/pop
// commands, returns popped values and guards against over/underflow.
module queue_calc_sequencer
    import queue_calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 5,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            token_valid,
    output logic            token_ready,
    input  logic            token_is_op,
    input  logic [W-1:0]    token_data,
    input  logic [2*W-1:0]  q_top_conc,
    output logic [1:0]      q_opcode,
    output logic [W-1:0]    q_back,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W-1:0]    res_data,
    output logic [CW-1:0]   count,
    output logic            busy,
    output logic            err,
    output logic [1:0]      err_code,
    input  logic            clr_err
);

    state_e          state_q, state_d;
    logic [1:0]      q_opcode_q, q_opcode_d;
    logic [W-1:0]    q_back_q, q_back_d;
    logic            res_valid_q, res_valid_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [W-1:0]    front_a;
    logic [W-1:0]    alu_res;
    logic [2:0]      tok_op;

    assign front_a = q_top_conc[2*W-1:W];
    assign tok_op  = token_data[2:0];

    queue_calc_alu #(.W(W)) u_alu (
        .a      (front_a),
        .b      (q_top_conc[W-1:0]),
        .op     (tok_op),
        .result (alu_res)
    );

    always_comb begin
        state_d     = state_q;
        q_opcode_d  = Q_NOP;
        q_back_d    = q_back_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        count_d     = count_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        case (state_q)
            ST_IDLE: begin
                // Offending tokens are still consumed; only the queue is spared.
                if (token_valid) begin
                    if (!token_is_op) begin
                        if (count_q == CW'(DEPTH)) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OVF;
                            state_d    = ST_ERR;
                        end else begin
                            q_opcode_d = Q_PUSH;
                            q_back_d   = token_data;
                            count_d    = count_q + CW'(1);
                            state_d    = ST_ISSUE;
                        end
                    end else begin
                        case (tok_op)
                            OP_ILL: begin
                                err_d      = 1'b1;
                                err_code_d = ERR_ILL;
                                state_d    = ST_ERR;
                            end
                            OP_POP: begin
                                if (count_q == '0) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_UNF;
                                    state_d    = ST_ERR;
                                end else begin
                                    res_data_d  = front_a;
                                    res_valid_d = 1'b1;
                                    q_opcode_d  = Q_POP;
                                    count_d     = count_q - CW'(1);
                                    state_d     = ST_OUT;
                                end
                            end
                            default: begin
                                if (count_q < CW'(2)) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_UNF;
                                    state_d    = ST_ERR;
                                end else begin
                                    q_opcode_d = Q_REPLACE;
                                    q_back_d   = alu_res;
                                    count_d    = count_q - CW'(1);
                                    state_d    = ST_ISSUE;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_opcode_q  <= Q_NOP;
            q_back_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            q_opcode_q  <= q_opcode_d;
            q_back_q    <= q_back_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign token_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign q_opcode    = q_opcode_q;
    assign q_back      = q_back_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign count       = count_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
